// File: rtl/regfetch_scoreboard.sv
// Register-fetch issue scoreboard: tracks pending vector/scalar writes and stalls hazarding instructions.
// Optional statistics counters are enabled with `define SCOREBOARD_STATS_EN.
module regfetch_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic        issue_valid,
    output logic [31:0] issue_instruction,
    input  logic        wb_valid,
    input  logic        wb_vec,
    input  logic [4:0]  wb_addr,
    input  logic        drain_req,
    output logic        drain_ack,
    output logic [31:0] busy_v,
    output logic [31:0] busy_s
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] issue_cnt
`endif
);

    // Opcode encoding of instruction[31:27]; values 18..31 are undefined.
    localparam logic [4:0] OP_NOOP   = 5'd0;
    localparam logic [4:0] OP_ADD    = 5'd1;
    localparam logic [4:0] OP_SUB    = 5'd2;
    localparam logic [4:0] OP_XOR    = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_ORR    = 5'd5;
    localparam logic [4:0] OP_SLV    = 5'd6;
    localparam logic [4:0] OP_SRV    = 5'd7;
    localparam logic [4:0] OP_ROL    = 5'd8;
    localparam logic [4:0] OP_ROR    = 5'd9;
    localparam logic [4:0] OP_LDV_I  = 5'd10;
    localparam logic [4:0] OP_LDV_R  = 5'd11;
    localparam logic [4:0] OP_STR_I  = 5'd12;
    localparam logic [4:0] OP_STR_R  = 5'd13;
    localparam logic [4:0] OP_MOVS_I = 5'd14;
    localparam logic [4:0] OP_MOVS_R = 5'd15;
    localparam logic [4:0] OP_MOVV_I = 5'd16;
    localparam logic [4:0] OP_MOVV_R = 5'd17;

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

    state_t      state_q, state_d;
    logic        issue_valid_q, issue_valid_d;
    logic [31:0] issue_instruction_q, issue_instruction_d;
    logic [31:0] busy_v_q, busy_v_d;
    logic [31:0] busy_s_q, busy_s_d;

    logic [4:0] opcode, rd, ra, rb;
    logic       form;
    logic       ra_v, ra_s, rb_v, rb_s, rd_v_src, dst_v, dst_s;
    logic       hazard, accept;

    assign opcode = instruction[31:27];
    assign rd     = instruction[26:22];
    assign ra     = instruction[21:17];
    assign rb     = instruction[4:0];
    assign form   = instruction[14];

    always_comb begin
        ra_v     = 1'b0;
        ra_s     = 1'b0;
        rb_v     = 1'b0;
        rb_s     = 1'b0;
        rd_v_src = 1'b0;
        dst_v    = 1'b0;
        dst_s    = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_ORR: begin
                ra_v  = 1'b1;
                rb_v  = 1'b1;
                dst_v = 1'b1;
            end
            OP_SLV, OP_SRV, OP_ROL, OP_ROR: begin
                ra_v  = 1'b1;
                rb_s  = ~form;
                dst_v = 1'b1;
            end
            OP_LDV_I: begin
                ra_s  = 1'b1;
                dst_v = 1'b1;
            end
            OP_LDV_R: begin
                ra_s  = 1'b1;
                rb_s  = 1'b1;
                dst_v = 1'b1;
            end
            OP_STR_I: begin
                rd_v_src = 1'b1;
                ra_s     = 1'b1;
            end
            OP_STR_R: begin
                rd_v_src = 1'b1;
                ra_s     = 1'b1;
                rb_s     = 1'b1;
            end
            OP_MOVS_I: dst_s = 1'b1;
            OP_MOVS_R: begin
                ra_s  = 1'b1;
                dst_s = 1'b1;
            end
            OP_MOVV_I: dst_v = 1'b1;
            OP_MOVV_R: begin
                ra_v  = 1'b1;
                dst_v = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazards look only at the registered maps: a writeback this cycle does not unblock until next cycle.
    always_comb begin
        hazard = (ra_v && busy_v_q[ra]) || (ra_s && busy_s_q[ra]) ||
                 (rb_v && busy_v_q[rb]) || (rb_s && busy_s_q[rb]) ||
                 ((rd_v_src || dst_v) && busy_v_q[rd]) ||
                 (dst_s && busy_s_q[rd]);
    end

    assign inst_ready = rst_n && (state_q == RUN) && !hazard;
    assign accept     = inst_valid && inst_ready;

    // Writeback clears first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_v_d = busy_v_q;
        busy_s_d = busy_s_q;
        if (wb_valid) begin
            if (wb_vec) begin
                busy_v_d[wb_addr] = 1'b0;
            end else begin
                busy_s_d[wb_addr] = 1'b0;
            end
        end
        if (accept && dst_v) begin
            busy_v_d[rd] = 1'b1;
        end
        if (accept && dst_s) begin
            busy_s_d[rd] = 1'b1;
        end
        issue_valid_d       = accept;
        issue_instruction_d = accept ? instruction : issue_instruction_q;
    end

    // DRAIN completes when the maps will be empty after this edge, so the final writeback reaches IDLE at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if ((busy_v_d == 32'd0) && (busy_s_d == 32'd0)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= RUN;
            issue_valid_q       <= 1'b0;
            issue_instruction_q <= 32'd0;
            busy_v_q            <= 32'd0;
            busy_s_q            <= 32'd0;
        end else begin
            state_q             <= state_d;
            issue_valid_q       <= issue_valid_d;
            issue_instruction_q <= issue_instruction_d;
            busy_v_q            <= busy_v_d;
            busy_s_q            <= busy_s_d;
        end
    end

    assign issue_valid       = issue_valid_q;
    assign issue_instruction = issue_instruction_q;
    assign busy_v            = busy_v_q;
    assign busy_s            = busy_s_q;
    assign drain_ack         = (state_q == IDLE);

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;

    // Stall counter saturates; issue counter wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if ((state_q == RUN) && inst_valid && !inst_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (accept) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            issue_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;
`endif

endmodule
